// File: rtl/collision_pkg.sv
// Shared constants and types for the wall-stream producer, this checker and hero_ctl.
// Keeping tile, hero and screen geometry here lets all three blocks use the same numbers.
package collision_pkg;

    localparam int COORD_W = 12;
    localparam int CALC_W  = 14;

    localparam int COL_UP    = 0;
    localparam int COL_DOWN  = 1;
    localparam int COL_LEFT  = 2;
    localparam int COL_RIGHT = 3;

    localparam int TILE_SIZE = 64;
    localparam int HERO_W    = 48;
    localparam int HERO_H    = 48;
    localparam int STEP      = 1;
    localparam int SCREEN_W  = 960;
    localparam int SCREEN_H  = 640;

    typedef logic signed [CALC_W-1:0] calc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Screen coordinates are unsigned; two spare bits keep hy-STEP and far-edge sums from wrapping.
    function automatic calc_t to_calc(input logic [COORD_W-1:0] v);
        return calc_t'({2'b00, v});
    endfunction

endpackage

// File: rtl/box_probe.sv
// Combinational blocked-direction flags for one wall tile against the hero box.
// A tile already overlapping the hero blocks nothing.
module box_probe #(
    parameter int TILE_SIZE = collision_pkg::TILE_SIZE,
    parameter int HERO_W    = collision_pkg::HERO_W,
    parameter int HERO_H    = collision_pkg::HERO_H,
    parameter int STEP      = collision_pkg::STEP
) (
    input  logic [11:0] hero_x_i,
    input  logic [11:0] hero_y_i,
    input  logic [11:0] wall_x_i,
    input  logic [11:0] wall_y_i,
    output logic [3:0]  flags_o
);
    import collision_pkg::*;

    localparam calc_t T_C    = calc_t'(TILE_SIZE);
    localparam calc_t W_C    = calc_t'(HERO_W);
    localparam calc_t H_C    = calc_t'(HERO_H);
    localparam calc_t STEP_C = calc_t'(STEP);

    calc_t hx, hy, wx, wy;
    logic  xov, yov;

    // NOTE: every output gets a default before any conditional assignment so no latch is inferred.
    always_comb begin
        flags_o = '0;
        hx  = to_calc(hero_x_i);
        hy  = to_calc(hero_y_i);
        wx  = to_calc(wall_x_i);
        wy  = to_calc(wall_y_i);
        xov = (wx < hx + W_C) && (wx + T_C > hx);
        yov = (wy < hy + H_C) && (wy + T_C > hy);
        if (!(xov && yov)) begin
            flags_o[COL_UP]    = xov && (wy + T_C > hy - STEP_C) && (wy < hy);
            flags_o[COL_DOWN]  = xov && (wy < hy + H_C + STEP_C) && (wy + T_C > hy + H_C);
            flags_o[COL_LEFT]  = yov && (wx + T_C > hx - STEP_C) && (wx < hx);
            flags_o[COL_RIGHT] = yov && (wx < hx + W_C + STEP_C) && (wx + T_C > hx + W_C);
        end
    end

endmodule

// File: rtl/wall_collision_checker.sv
// Per-frame wall scan: latches the hero box, tests each streamed tile in a two-stage
// pipeline and publishes the accumulated up/down/left/right blocked vector.
module wall_collision_checker #(
    parameter int TILE_SIZE = collision_pkg::TILE_SIZE,
    parameter int HERO_W    = collision_pkg::HERO_W,
    parameter int HERO_H    = collision_pkg::HERO_H,
    parameter int STEP      = collision_pkg::STEP,
    parameter int SCREEN_W  = collision_pkg::SCREEN_W,
    parameter int SCREEN_H  = collision_pkg::SCREEN_H
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [11:0] hero_x_pos,
    input  logic [11:0] hero_y_pos,
    input  logic        wall_valid,
    output logic        wall_ready,
    input  logic [11:0] wall_x_pos,
    input  logic [11:0] wall_y_pos,
    input  logic        wall_last,
    output logic [3:0]  collision,
    output logic        collision_valid,
    output logic        busy
);
    import collision_pkg::*;

    localparam calc_t W_C    = calc_t'(HERO_W);
    localparam calc_t H_C    = calc_t'(HERO_H);
    localparam calc_t STEP_C = calc_t'(STEP);
    localparam calc_t SW_C   = calc_t'(SCREEN_W);
    localparam calc_t SH_C   = calc_t'(SCREEN_H);

    state_e      state_q, state_d;
    logic [11:0] hero_x_q, hero_y_q;
    logic [11:0] s1_x_q, s1_y_q;
    logic        s1_valid_q, s2_valid_q;
    logic [3:0]  s2_flags_q, probe_flags, edge_flags;
    logic [3:0]  acc_q, acc_d, collision_q;
    logic        collision_valid_q, publish, accept;
    calc_t       ex, ey;

    assign wall_ready      = (state_q == ST_SCAN);
    assign busy            = (state_q != ST_IDLE);
    assign accept          = wall_valid && wall_ready;
    assign collision       = collision_q;
    assign collision_valid = collision_valid_q;

    // Screen borders act as walls; evaluated on the incoming hero so they seed the accumulator.
    always_comb begin
        edge_flags = '0;
        ex = to_calc(hero_x_pos);
        ey = to_calc(hero_y_pos);
        edge_flags[COL_UP]    = ey < STEP_C;
        edge_flags[COL_LEFT]  = ex < STEP_C;
        edge_flags[COL_DOWN]  = ey + H_C + STEP_C > SH_C;
        edge_flags[COL_RIGHT] = ex + W_C + STEP_C > SW_C;
    end

    box_probe #(
        .TILE_SIZE(TILE_SIZE),
        .HERO_W   (HERO_W),
        .HERO_H   (HERO_H),
        .STEP     (STEP)
    ) u_probe (
        .hero_x_i(hero_x_q),
        .hero_y_i(hero_y_q),
        .wall_x_i(s1_x_q),
        .wall_y_i(s1_y_q),
        .flags_o (probe_flags)
    );

    // frame_start in any state restarts the scan; in DONE the pulse already issued still stands.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        publish = 1'b0;
        if (s2_valid_q) acc_d = acc_q | s2_flags_q;
        unique case (state_q)
            ST_IDLE:  ;
            ST_SCAN:  if (accept && wall_last) state_d = ST_DRAIN;
            ST_DRAIN: if (!s1_valid_q && !s2_valid_q) begin
                state_d = ST_DONE;
                publish = 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (frame_start) begin
            state_d = ST_SCAN;
            acc_d   = edge_flags;
            publish = 1'b0;
        end
    end

    // NOTE: control state is under async reset; the datapath registers in the next block are not,
    // because they are only ever read behind s1_valid_q/s2_valid_q or after a frame_start reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= ST_IDLE;
            acc_q             <= '0;
            s1_valid_q        <= 1'b0;
            s2_valid_q        <= 1'b0;
            collision_q       <= '0;
            collision_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            acc_q             <= acc_d;
            s1_valid_q        <= accept && !frame_start;
            s2_valid_q        <= s1_valid_q && !frame_start;
            collision_valid_q <= publish;
            if (publish) collision_q <= acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (frame_start) begin
            hero_x_q <= hero_x_pos;
            hero_y_q <= hero_y_pos;
        end
        if (accept) begin
            s1_x_q <= wall_x_pos;
            s1_y_q <= wall_y_pos;
        end
        if (s1_valid_q) s2_flags_q <= probe_flags;
    end

endmodule

// File: tb/tb_wall_collision_checker.sv
// Directed and randomized frames for wall_collision_checker, checked against a
// box-shift geometric model (a direction is blocked if moving the hero one step would hit).
module tb_wall_collision_checker;
    import collision_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [11:0] hero_x_pos, hero_y_pos;
    logic        wall_valid;
    logic        wall_ready;
    logic [11:0] wall_x_pos, wall_y_pos;
    logic        wall_last;
    logic [3:0]  collision;
    logic        collision_valid;
    logic        busy;

    int          compared   = 0;
    int          mismatched = 0;
    int          cv_count   = 0;
    int          m_hx, m_hy;
    logic [3:0]  model_acc;
    int          wq_x[$];
    int          wq_y[$];

    wall_collision_checker dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .hero_x_pos     (hero_x_pos),
        .hero_y_pos     (hero_y_pos),
        .wall_valid     (wall_valid),
        .wall_ready     (wall_ready),
        .wall_x_pos     (wall_x_pos),
        .wall_y_pos     (wall_y_pos),
        .wall_last      (wall_last),
        .collision      (collision),
        .collision_valid(collision_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (collision_valid === 1'b1) cv_count <= cv_count + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit boxes_overlap(input int ax, ay, aw, ah, bx, by, bw, bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    function automatic logic [3:0] ref_wall(input int hx, hy, wx, wy);
        logic [3:0] f;
        int dx[4];
        int dy[4];
        f  = '0;
        dx = '{0, 0, -STEP, STEP};
        dy = '{-STEP, STEP, 0, 0};
        if (boxes_overlap(hx, hy, HERO_W, HERO_H, wx, wy, TILE_SIZE, TILE_SIZE)) return f;
        for (int d = 0; d < 4; d++)
            f[d] = boxes_overlap(hx + dx[d], hy + dy[d], HERO_W, HERO_H,
                                 wx, wy, TILE_SIZE, TILE_SIZE);
        return f;
    endfunction

    function automatic logic [3:0] ref_edges(input int hx, hy);
        logic [3:0] f;
        f[COL_UP]    = (hy - STEP) < 0;
        f[COL_DOWN]  = (hy + STEP + HERO_H) > SCREEN_H;
        f[COL_LEFT]  = (hx - STEP) < 0;
        f[COL_RIGHT] = (hx + STEP + HERO_W) > SCREEN_W;
        return f;
    endfunction

    function automatic int pick_off(input int hero_ext);
        case ($urandom_range(0, 7))
            0: return -TILE_SIZE;
            1: return -TILE_SIZE - 1;
            2: return -TILE_SIZE + 1;
            3: return hero_ext;
            4: return hero_ext + 1;
            5: return hero_ext - 1;
            6: return 0;
            default: return int'($urandom_range(0, 200)) - 100;
        endcase
    endfunction

    task automatic start_frame(input int hx, input int hy);
        frame_start = 1'b1;
        hero_x_pos  = 12'(hx);
        hero_y_pos  = 12'(hy);
        @(posedge clk); #1;
        frame_start = 1'b0;
        m_hx        = hx;
        m_hy        = hy;
        model_acc   = ref_edges(hx, hy);
    endtask

    task automatic send_beats(input bit last, input bit toggle);
        int i     = 0;
        int guard = 0;
        bit took;
        while (i < wq_x.size() && guard < 200) begin
            wall_valid = toggle ? guard[0] : 1'b1;
            wall_x_pos = 12'(wq_x[i]);
            wall_y_pos = 12'(wq_y[i]);
            wall_last  = last && (i == wq_x.size() - 1);
            took       = wall_valid && wall_ready;
            @(posedge clk); #1;
            if (took) begin
                model_acc = model_acc | ref_wall(m_hx, m_hy, wq_x[i], wq_y[i]);
                i++;
            end
            guard++;
        end
        wall_valid = 1'b0;
        wall_last  = 1'b0;
        check("beats_accepted", i, wq_x.size());
    endtask

    task automatic finish_frame(input string tag, input logic [3:0] exp);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k < 3) check({tag, "_cv_early"}, collision_valid, 1'b0);
        end
        check({tag, "_cv"}, collision_valid, 1'b1);
        check({tag, "_collision"}, collision, exp);
        check({tag, "_busy_done"}, busy, 1'b1);
        @(posedge clk); #1;
        check({tag, "_cv_pulse"}, collision_valid, 1'b0);
        check({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        int cv_before, hx, hy, n, ox, oy;
        rst         = 1'b0;
        frame_start = 1'b0;
        hero_x_pos  = '0;
        hero_y_pos  = '0;
        wall_valid  = 1'b0;
        wall_x_pos  = '0;
        wall_y_pos  = '0;
        wall_last   = 1'b0;
        #12;
        check("reset_collision", collision, 4'b0000);
        check("reset_cv", collision_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_ready", wall_ready, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        start_frame(100, 100);
        check("scan_busy", busy, 1'b1);
        check("scan_ready", wall_ready, 1'b1);
        wq_x = '{148}; wq_y = '{100};
        send_beats(1'b1, 1'b0);
        finish_frame("right", 4'b1000);

        start_frame(100, 100);
        wq_x = '{36, 100, 100}; wq_y = '{100, 36, 148};
        send_beats(1'b1, 1'b0);
        finish_frame("up_down_left", 4'b0111);

        start_frame(0, 0);
        wq_x = '{500}; wq_y = '{500};
        send_beats(1'b1, 1'b0);
        finish_frame("screen_corner", 4'b0101);

        start_frame(100, 100);
        wq_x = '{148}; wq_y = '{100};
        send_beats(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #4 rst = 1'b0;
        #1;
        check("midreset_collision", collision, 4'b0000);
        check("midreset_busy", busy, 1'b0);
        check("midreset_ready", wall_ready, 1'b0);
        check("midreset_cv", collision_valid, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        start_frame(100, 100);
        wq_x = '{36}; wq_y = '{100};
        send_beats(1'b1, 1'b0);
        finish_frame("after_reset", 4'b0100);

        cv_before = cv_count;
        start_frame(200, 200);
        wq_x = '{500, 600, 0, 800, 400}; wq_y = '{500, 100, 600, 300, 0};
        send_beats(1'b1, 1'b1);
        finish_frame("toggled_far", 4'b0000);
        check("toggled_single_cv", cv_count - cv_before, 1);

        cv_before  = cv_count;
        wall_valid = 1'b1;
        wall_x_pos = 12'd148;
        wall_y_pos = 12'd100;
        wall_last  = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_ready_low", wall_ready, 1'b0);
        end
        wall_valid = 1'b0;
        wall_last  = 1'b0;
        check("idle_no_cv", cv_count - cv_before, 0);

        cv_before = cv_count;
        start_frame(100, 100);
        wq_x = '{148, 500}; wq_y = '{100, 500};
        send_beats(1'b0, 1'b0);
        start_frame(100, 100);
        wq_x = '{500, 300}; wq_y = '{500, 300};
        send_beats(1'b1, 1'b0);
        finish_frame("abort", 4'b0000);
        check("abort_single_cv", cv_count - cv_before, 1);

        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 9))
                0:       hx = 0;
                1:       hx = SCREEN_W - HERO_W;
                default: hx = int'($urandom_range(0, SCREEN_W - HERO_W));
            endcase
            case ($urandom_range(0, 9))
                0:       hy = 0;
                1:       hy = SCREEN_H - HERO_H;
                default: hy = int'($urandom_range(0, SCREEN_H - HERO_H));
            endcase
            cv_before = cv_count;
            if ($urandom_range(0, 4) == 0) begin
                start_frame(hx, hy);
                wq_x = '{hx + HERO_W}; wq_y = '{hy};
                send_beats(1'b0, 1'b0);
            end
            start_frame(hx, hy);
            wq_x.delete();
            wq_y.delete();
            n = int'($urandom_range(1, 6));
            for (int b = 0; b < n; b++) begin
                ox = hx + pick_off(HERO_W);
                oy = hy + pick_off(HERO_H);
                wq_x.push_back(ox < 0 ? 0 : ox);
                wq_y.push_back(oy < 0 ? 0 : oy);
            end
            send_beats(1'b1, 1'($urandom_range(0, 1)));
            finish_frame("random", model_acc);
            check("random_single_cv", cv_count - cv_before, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
